// File: rtl/af6ces48rtl_fifoid_thr_pkg.sv
// Shared defaults and pointer-wrap helper for the multi-channel FIFO-ID controller.
package af6ces48rtl_fifoid_thr_pkg;

  localparam int ADD_DEF   = 8;
  localparam int LEN_DEF   = 256;
  localparam int ADDCH_DEF = 7;
  localparam int NUMCH_DEF = 128;

  // Slices need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned len);
    return (ptr == len - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/af6ces48rtl_flushsync.sv
// Two-flop synchroniser for the global flush level; powers up asserted.
module af6ces48rtl_flushsync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta_reg;
  (* preserve *) logic sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/af6ces48rtl_fifoid_thr.sv
// Per-channel FIFO pointer/status manager over one shared RAM split into NUMCH slices of LEN entries.
module af6ces48rtl_fifoid_thr
  import af6ces48rtl_fifoid_thr_pkg::*;
#(
  parameter int ADD   = ADD_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int ADDCH = ADDCH_DEF,
  parameter int NUMCH = NUMCH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ffwr,
  input  logic [ADDCH-1:0]     ffwrid,
  input  logic                 ffrd,
  input  logic [ADDCH-1:0]     ffrdid,
  input  logic [ADD:0]         afthres,
  input  logic                 chflush,
  input  logic [ADDCH-1:0]     chflushid,
  input  logic                 flush,
  input  logic                 errclr,
  output logic [NUMCH-1:0]     fffull,
  output logic [NUMCH-1:0]     ffafull,
  output logic [NUMCH-1:0]     ffnemp,
  output logic [ADD:0]         rdlen,
  output logic                 write,
  output logic [ADD+ADDCH-1:0] wraddr,
  output logic                 read,
  output logic [ADD+ADDCH-1:0] rdaddr,
  output logic [NUMCH-1:0]     ovferr,
  output logic [NUMCH-1:0]     udferr
);

  localparam logic [ADD:0] LEN_C = (ADD+1)'(LEN);

  logic             flush2;
  logic [NUMCH-1:0] wsel, rsel, fsel;
  logic [NUMCH-1:0] wroom, ravail;
  logic [ADD:0]     cnt_arr   [NUMCH];
  logic [ADD-1:0]   wrptr_arr [NUMCH];
  logic [ADD-1:0]   rdptr_arr [NUMCH];
  logic [ADD-1:0]   wrptr_sel, rdptr_sel;
  logic             wr_fl_hit, rd_fl_hit;

  af6ces48rtl_flushsync u_flushsync (
    .clk  (clk),
    .rst  (rst),
    .din  (flush),
    .dout (flush2)
  );

  // Out-of-range IDs decode to no channel, so they are never accepted and touch no state.
  generate
    for (genvar gi = 0; gi < NUMCH; gi++) begin : g_dec
      assign wsel[gi]   = (ffwrid    == ADDCH'(gi));
      assign rsel[gi]   = (ffrdid    == ADDCH'(gi));
      assign fsel[gi]   = (chflushid == ADDCH'(gi));
      assign wroom[gi]  = wsel[gi] & (cnt_arr[gi] != LEN_C);
      assign ravail[gi] = rsel[gi] & (cnt_arr[gi] != '0);
    end
  endgenerate

  assign wr_fl_hit = chflush & (chflushid == ffwrid);
  assign rd_fl_hit = chflush & (chflushid == ffrdid);

  // Read uses the pre-write count: no read-through of a same-cycle write.
  assign write = ffwr & ~flush2 & ~wr_fl_hit & (|wroom);
  assign read  = ffrd & ~flush2 & ~rd_fl_hit & (|ravail);

  always_comb begin
    wrptr_sel = '0;
    rdptr_sel = '0;
    rdlen     = '0;
    for (int i = 0; i < NUMCH; i++) begin
      if (wsel[i]) wrptr_sel = wrptr_arr[i];
      if (rsel[i]) begin
        rdptr_sel = rdptr_arr[i];
        rdlen     = cnt_arr[i];
      end
    end
  end

  assign wraddr = {ffwrid, wrptr_sel};
  assign rdaddr = {ffrdid, rdptr_sel};

  generate
    for (genvar gi = 0; gi < NUMCH; gi++) begin : g_ch
      logic [ADD-1:0] wrptr_reg, wrptr_next;
      logic [ADD-1:0] rdptr_reg, rdptr_next;
      logic [ADD:0]   cnt_reg, cnt_next;
      logic           full_reg, afull_reg, nemp_reg, ovf_reg, udf_reg;
      logic           wacc, racc, clr, ovf_set, udf_set;

      assign wacc    = write & wsel[gi];
      assign racc    = read & rsel[gi];
      assign clr     = flush2 | (chflush & fsel[gi]);
      assign ovf_set = ffwr & wsel[gi] & (cnt_reg == LEN_C) & ~(chflush & fsel[gi]) & ~flush2;
      assign udf_set = ffrd & rsel[gi] & (cnt_reg == '0)    & ~(chflush & fsel[gi]) & ~flush2;

      always_comb begin
        wrptr_next = wrptr_reg;
        rdptr_next = rdptr_reg;
        cnt_next   = cnt_reg;
        if (clr) begin
          wrptr_next = '0;
          rdptr_next = '0;
          cnt_next   = '0;
        end else begin
          if (wacc) wrptr_next = ADD'(next_ptr(32'(wrptr_reg), LEN));
          if (racc) rdptr_next = ADD'(next_ptr(32'(rdptr_reg), LEN));
          if (wacc && !racc)      cnt_next = cnt_reg + (ADD+1)'(1);
          else if (racc && !wacc) cnt_next = cnt_reg - (ADD+1)'(1);
        end
      end

      // Status is registered from the next-state count, so it lags an op by one cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wrptr_reg <= '0;
          rdptr_reg <= '0;
          cnt_reg   <= '0;
          full_reg  <= 1'b0;
          afull_reg <= 1'b0;
          nemp_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
          udf_reg   <= 1'b0;
        end else begin
          wrptr_reg <= wrptr_next;
          rdptr_reg <= rdptr_next;
          cnt_reg   <= cnt_next;
          full_reg  <= (cnt_next == LEN_C);
          afull_reg <= ~clr & (cnt_next >= afthres);
          nemp_reg  <= (cnt_next != '0);
          ovf_reg   <= (ovf_reg & ~errclr) | ovf_set;
          udf_reg   <= (udf_reg & ~errclr) | udf_set;
        end
      end

      assign cnt_arr[gi]   = cnt_reg;
      assign wrptr_arr[gi] = wrptr_reg;
      assign rdptr_arr[gi] = rdptr_reg;
      assign fffull[gi]    = full_reg;
      assign ffafull[gi]   = afull_reg;
      assign ffnemp[gi]    = nemp_reg;
      assign ovferr[gi]    = ovf_reg;
      assign udferr[gi]    = udf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_af6ces48rtl_fifoid_thr.sv
// Directed bench for the FIFO-ID controller: LEN=200 slices, 12 channels of a 7-bit ID space.
module tb_af6ces48rtl_fifoid_thr;

  localparam int ADD   = 8;
  localparam int LEN   = 200;
  localparam int ADDCH = 7;
  localparam int NUMCH = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ffwr, ffrd, chflush, flush, errclr;
  logic [ADDCH-1:0]     ffwrid, ffrdid, chflushid;
  logic [ADD:0]         afthres;
  logic [NUMCH-1:0]     fffull, ffafull, ffnemp, ovferr, udferr;
  logic [ADD:0]         rdlen;
  logic                 write, read;
  logic [ADD+ADDCH-1:0] wraddr, rdaddr;

  int n_chk  = 0;
  int n_pass = 0;

  af6ces48rtl_fifoid_thr #(.ADD(ADD), .LEN(LEN), .ADDCH(ADDCH), .NUMCH(NUMCH)) dut (
    .clk(clk), .rst(rst),
    .ffwr(ffwr), .ffwrid(ffwrid), .ffrd(ffrd), .ffrdid(ffrdid),
    .afthres(afthres), .chflush(chflush), .chflushid(chflushid),
    .flush(flush), .errclr(errclr),
    .fffull(fffull), .ffafull(ffafull), .ffnemp(ffnemp), .rdlen(rdlen),
    .write(write), .wraddr(wraddr), .read(read), .rdaddr(rdaddr),
    .ovferr(ovferr), .udferr(udferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ffwr = 1'b0; ffrd = 1'b0; chflush = 1'b0; errclr = 1'b0;
  endtask

  task automatic do_wr(input logic [ADDCH-1:0] id, input int n);
    ffwr = 1'b1; ffwrid = id;
    repeat (n) tick();
    ffwr = 1'b0;
  endtask

  task automatic do_rd(input logic [ADDCH-1:0] id, input int n);
    ffrd = 1'b1; ffrdid = id;
    repeat (n) tick();
    ffrd = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; afthres = 9'd4;
    ffwrid = '0; ffrdid = '0; chflushid = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fffull",  64'(fffull),  64'h0);
    check("rst_ffnemp",  64'(ffnemp),  64'h0);
    check("rst_ffafull", 64'(ffafull), 64'h0);
    check("rst_ovferr",  64'(ovferr),  64'h0);
    rst = 1'b1;

    // Block stays flushed for two edges after reset release.
    ffwr = 1'b1; ffwrid = 7'd3;
    #1 check("flush_hold0", 64'(write), 64'd0);
    tick();
    check("flush_hold1", 64'(write), 64'd0);
    tick();
    check("ch3_write", 64'(write), 64'd1);
    check("ch3_wraddr", 64'(wraddr), 64'h300);
    tick();
    ffwr = 1'b0;

    // Fill ch5 to LEN, overflow, drain.
    ffwr = 1'b1; ffwrid = 7'd5; ffrdid = 7'd5;
    repeat (199) tick();
    check("ch5_full199", 64'(fffull[5]), 64'd0);
    check("ch5_wraddr199", 64'(wraddr), 64'h5C7);
    check("ch5_wr200", 64'(write), 64'd1);
    tick();
    check("ch5_full200", 64'(fffull[5]), 64'd1);
    check("ch5_wrap", 64'(wraddr), 64'h500);
    check("ch5_wr201", 64'(write), 64'd0);
    check("ch5_rdlen", 64'(rdlen), 64'd200);
    tick();
    ffwr = 1'b0;
    check("ch5_ovferr", 64'(ovferr), 64'h020);
    do_rd(7'd5, 200);
    #1;
    check("ch5_drained", 64'(rdlen), 64'd0);
    check("ch5_nemp", 64'(ffnemp[5]), 64'd0);
    check("ch5_rdwrap", 64'(rdaddr), 64'h500);
    check("ch5_udferr", 64'(udferr), 64'h0);

    // Almost-full threshold of 4 on ch1.
    do_wr(7'd1, 3);
    check("ch1_af3", 64'(ffafull[1]), 64'd0);
    do_wr(7'd1, 1);
    check("ch1_af4", 64'(ffafull[1]), 64'd1);
    do_rd(7'd1, 1);
    ffrdid = 7'd1;
    #1;
    check("ch1_af_fall", 64'(ffafull[1]), 64'd0);
    check("ch1_rdlen", 64'(rdlen), 64'd3);

    // Same-channel write+read on ch2 holding 3.
    do_wr(7'd2, 3);
    ffwr = 1'b1; ffwrid = 7'd2; ffrd = 1'b1; ffrdid = 7'd2;
    #1;
    check("ch2_write", 64'(write), 64'd1);
    check("ch2_read", 64'(read), 64'd1);
    check("ch2_wraddr0", 64'(wraddr), 64'h203);
    check("ch2_rdaddr0", 64'(rdaddr), 64'h200);
    tick();
    idle();
    #1;
    check("ch2_rdlen", 64'(rdlen), 64'd3);
    check("ch2_wraddr1", 64'(wraddr), 64'h204);
    check("ch2_rdaddr1", 64'(rdaddr), 64'h201);

    // Write+read to empty ch7: no read-through.
    ffwr = 1'b1; ffwrid = 7'd7; ffrd = 1'b1; ffrdid = 7'd7;
    #1;
    check("ch7_write", 64'(write), 64'd1);
    check("ch7_read", 64'(read), 64'd0);
    tick();
    idle();
    #1;
    check("ch7_udferr", 64'(udferr), 64'h080);
    check("ch7_rdlen", 64'(rdlen), 64'd1);

    // chflush on ch9 beats a same-cycle write; ch0 untouched.
    do_wr(7'd0, 5);
    do_wr(7'd9, 5);
    chflush = 1'b1; chflushid = 7'd9; ffwr = 1'b1; ffwrid = 7'd9;
    #1;
    check("ch9_fl_write", 64'(write), 64'd0);
    tick();
    idle();
    ffrdid = 7'd9;
    #1;
    check("ch9_rdlen", 64'(rdlen), 64'd0);
    check("ch9_nemp", 64'(ffnemp[9]), 64'd0);
    check("ch9_ovferr", 64'(ovferr), 64'h020);
    check("ch9_udferr", 64'(udferr), 64'h080);
    ffrdid = 7'd0;
    #1;
    check("ch0_rdlen", 64'(rdlen), 64'd5);
    errclr = 1'b1;
    tick();
    errclr = 1'b0;
    check("errclr_ovf", 64'(ovferr), 64'h0);
    check("errclr_udf", 64'(udferr), 64'h0);

    // Out-of-range ID 13 is ignored entirely.
    ffwr = 1'b1; ffwrid = 7'd13; ffrd = 1'b1; ffrdid = 7'd13;
    #1;
    check("oor_write", 64'(write), 64'd0);
    check("oor_read", 64'(read), 64'd0);
    tick();
    idle();
    check("oor_udferr", 64'(udferr), 64'h0);
    check("oor_nemp", 64'(ffnemp), 64'h08F);

    // Global flush clears state but holds sticky errors.
    do_rd(7'd4, 1);
    check("ch4_udferr", 64'(udferr), 64'h010);
    flush = 1'b1;
    repeat (3) tick();
    ffwr = 1'b1; ffwrid = 7'd0;
    #1;
    check("gfl_write", 64'(write), 64'd0);
    check("gfl_nemp", 64'(ffnemp), 64'h0);
    check("gfl_udf_held", 64'(udferr), 64'h010);
    ffwr = 1'b0;
    flush = 1'b0; afthres = 9'd0;
    repeat (3) tick();
    check("af_thres0", 64'(ffafull), 64'hFFF);
    check("post_fl_nemp", 64'(ffnemp), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
